// File: rtl/demux_pkg.sv
// Shared definitions for the nibble demultiplexer.
//   DEMUX_DATA_W : default payload width in bits
//   slot_state_t : state of a one-entry destination buffer (EMPTY / FULL)
package demux_pkg;

  localparam int DEMUX_DATA_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready buffer used as a demux destination.
//
// Handshake: a transfer happens on a rising edge where valid && ready on
// that side. in_ready is combinational: EMPTY, or FULL while out_ready is
// high, which means the buffer drains and refills on the same edge. ready
// never depends on valid on the same side.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   in_data/in_valid     payload offered to this slot (already steered)
//   in_ready             slot can take a payload this cycle
//   out_data/out_valid   buffered payload / buffer FULL
//   out_ready            downstream consumes the payload this cycle
//   state                current slot state, exposed for debug/checkers
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output slot_state_t       state
);

  slot_state_t       state_q;
  slot_state_t       state_d;
  logic [DATA_W-1:0] data_q;
  logic              load;

  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign state     = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A FULL slot that is drained and refilled on the same edge stays FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_valid) state_d = FULL;
      FULL:  if (out_ready && !in_valid) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Data is only written on a load, so it keeps its last value when EMPTY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= in_data;
    end
  end

endmodule

// File: rtl/nibble_demux.sv
// Two-way valid/ready demultiplexer with one-entry buffer per destination.
//
// Handshake: every port pair follows valid/ready; a transfer happens on a
// rising edge where both are high. in_ready reflects only the currently
// targeted buffer and never depends on in_valid, so changing the target
// while stalled simply retargets the pending offer.
//
// Configuration macro NIBBLE_DEMUX_AUTO_TOGGLE_EN: when defined, select is
// ignored and an internal toggle bit (reset 0) picks the destination,
// flipping after each accepted input transfer.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   in_data/in_valid/in_ready  upstream payload handshake
//   select                     destination (0 -> out0, 1 -> out1)
//   outN_data/outN_valid       registered payload per destination
//   outN_ready                 destination consumes payload this cycle
module nibble_demux
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              select,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready
);

  logic        target;
  logic        slot0_ready;
  logic        slot1_ready;
  slot_state_t slot0_state;
  slot_state_t slot1_state;

`ifdef NIBBLE_DEMUX_AUTO_TOGGLE_EN
  logic toggle_q;
  wire  unused_select = select;

  // Only accepted transfers advance the round-robin choice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggle_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign target = toggle_q;
`else
  assign target = select;
`endif

  // The upstream handshake sees only the targeted slot; the other slot
  // never receives in_valid, so it is untouched by the input side.
  assign in_ready = target ? slot1_ready : slot0_ready;

  demux_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid && !target),
    .in_ready  (slot0_ready),
    .out_data  (out0_data),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .state     (slot0_state)
  );

  demux_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid && target),
    .in_ready  (slot1_ready),
    .out_data  (out1_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .state     (slot1_state)
  );

  // Slot state is mirrored on out_valid; keep the debug states observable
  // without adding top-level ports.
  wire unused_states = (slot0_state == FULL) ^ (slot1_state == FULL);

endmodule
